vio_io_bridge: RTL and testbench
================================

# vio_io_bridge

Parametrised bridge between the VIO core and the student `top` in the remote-lab wrapper. It replaces the direct VIO-to-DUT wiring with registered switch forwarding and timed button presses. It also captures the DUT's multiplexed 7-segment display into a stable per-digit frame the VIO can read. Without it, the VIO only sees whatever anode/cathode pair is active at sample time.

## Interface
Parameters:
- `N_BTN`, 5, number of push buttons (order L, D, U, R, C from bit 0).
- `N_SW`, 16, switch width.
- `N_LED`, 16, LED width.
- `N_DIGITS`, 8, number of 7-segment digits (anode width).
- `PRESS_CYCLES`, 1_000_000, length of a timed press; must be ≥ 1.
- `STABLE_CYCLES`, 1000, consecutive identical samples required before a digit is captured; must be ≥ 2.
- `BLANK_CYCLES`, 10_000_000, cycles without a refresh after which a digit is cleared.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `btn_req`  in  N_BTN  VIO request per button.
- `btn_level`  in  N_BTN  VIO mode per button: 1 = level mode, 0 = timed-press mode.
- `sw_in`  in  N_SW  VIO switch values.
- `btn_out`  out  N_BTN  buttons to DUT.
- `btn_busy`  out  N_BTN  timed press in progress.
- `sw_out`  out  N_SW  switches to DUT.
- `anode`  in  N_DIGITS  DUT anodes, active-low.
- `cathode`  in  7  DUT segments, active-low.
- `dp`  in  1  DUT decimal point, active-low.
- `led_in`  in  N_LED  DUT LEDs.
- `led_out`  out  N_LED  LEDs to VIO.
- `digit_frame`  out  8*N_DIGITS  per-digit `{dp, g..a}`, active-high; digit i occupies bits [8i+7:8i].
- `frame_update`  out  1  one-cycle pulse when any digit value changes.

## Operation
- **Reset.** All outputs are 0. All counters are 0. `btn_req` history resets to all-ones, so a request held through reset does not fire. The display sample register resets to all-ones (blank).
- **Switches and LEDs.** Each passes through a single register stage.
- **Level-mode button.** `btn_out[i]` is `btn_req[i]` registered. Entering level mode aborts any active timed press on that button, and `btn_busy[i]` drops.
- **Timed-press button.**
  - Per-button FSM with states IDLE and PRESS.
  - IDLE → PRESS on a rising edge of `btn_req[i]` (current 1, previous 0). The counter loads PRESS_CYCLES.
  - In PRESS, `btn_out[i]` = 1 and `btn_busy[i]` = 1. The counter decrements each cycle. At 1 the FSM returns to IDLE.
  - Rising edges seen during PRESS are ignored; they are not queued.
- **Display capture.**
  - `{anode, dp, cathode}` is registered once per cycle. A stability counter increments when the sample equals the previous sample and resets to 0 otherwise. It saturates at STABLE_CYCLES-1.
  - Capture fires exactly once per stable period, on the cycle the counter reaches STABLE_CYCLES-1, but only if exactly one anode bit is low. Digit k (the low anode) is written with the inverted `{dp, cathode}`, and its age counter is zeroed.
  - All-high or multi-low anode patterns never capture.
- **Blanking.** Each digit has a saturating age counter. When it reaches BLANK_CYCLES, the digit is written to 0. A capture on the same cycle takes priority.
- **`frame_update`.** Pulses on any cycle where the `digit_frame` value changes, whether by capture or by blanking. No pulse when the captured value equals the stored value.

## Timing
- `sw_out` and `led_out`: 1-cycle latency.
- Level-mode `btn_out`: 1-cycle latency from `btn_req`.
- Timed press: `btn_req` is first seen high at edge k. `btn_out` is high for edges k+1 … k+PRESS_CYCLES and low at k+PRESS_CYCLES+1. `btn_busy` is identical to `btn_out`.
- A new rising edge is accepted no earlier than the cycle after PRESS ends.
- Display: a pattern first presented at edge k enters the sample register at k+1. With no change, `digit_frame` updates at edge k+STABLE_CYCLES+1. `frame_update` is high in that same cycle.
- `rst` asserted mid-press or mid-capture: next cycle, all outputs are 0 and the frame is cleared. `frame_update` is not pulsed by reset.

## Test plan
- **Switches.** Reset, then drive `sw_in`=16'hA5C3 → `sw_out`=16'hA5C3 one cycle later; during reset, `sw_out`=0.
- **Timed press.** PRESS_CYCLES=10. Pulse `btn_req[4]` for 1 cycle → `btn_out[4]` high for exactly 10 cycles. A second edge at cycle 5 of the press is ignored. An edge on cycle 11 starts a new press.
- **Level mode and reset history.** Set `btn_level[0]`=1 mid-press → `btn_out[0]` follows `btn_req[0]` next cycle and `btn_busy[0]`=0. Separately, hold `btn_req[1]`=1 through reset → no press occurs.
- **Capture.** STABLE_CYCLES=4. Drive anode=8'hFD, cathode=7'b1000000, dp=1 (a "0" on digit 1) for 3 cycles → no capture. Then drive the same pattern for 4 cycles → `digit_frame[15:8]`=8'h3F, and `frame_update` pulses once.
- **Invalid anodes and mux scan.** anode=8'hFC (two low) or 8'hFF, held 10 cycles → no change. A round-robin scan over 8 digits at 6 cycles per digit → all 8 digits captured correctly.
- **Blanking.** BLANK_CYCLES=100. Capture digit 2, then stop refreshing it → `digit_frame[23:16]`=0 after 100 cycles, with one `frame_update` pulse. Refreshing at 90-cycle intervals → the digit never blanks.

Source files
------------

// File: rtl/vio_io_bridge.sv
// Bridge between the VIO core and the student top: registered switches/LEDs,
// level or timed button presses, and capture of the multiplexed 7-seg display.
module vio_io_bridge #(
  parameter int N_BTN         = 5,
  parameter int N_SW          = 16,
  parameter int N_LED         = 16,
  parameter int N_DIGITS      = 8,
  parameter int PRESS_CYCLES  = 1_000_000,
  parameter int STABLE_CYCLES = 1000,
  parameter int BLANK_CYCLES  = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_BTN-1:0]      btn_req,
  input  logic [N_BTN-1:0]      btn_level,
  input  logic [N_SW-1:0]       sw_in,
  output logic [N_BTN-1:0]      btn_out,
  output logic [N_BTN-1:0]      btn_busy,
  output logic [N_SW-1:0]       sw_out,
  input  logic [N_DIGITS-1:0]   anode,
  input  logic [6:0]            cathode,
  input  logic                  dp,
  input  logic [N_LED-1:0]      led_in,
  output logic [N_LED-1:0]      led_out,
  output logic [8*N_DIGITS-1:0] digit_frame,
  output logic                  frame_update
);

  localparam int PCW = $clog2(PRESS_CYCLES + 1);
  localparam int SCW = $clog2(STABLE_CYCLES);
  localparam int ACW = $clog2(BLANK_CYCLES + 1);
  localparam int SMW = N_DIGITS + 8;

  localparam logic [PCW-1:0] PRESS_LOAD  = PCW'(PRESS_CYCLES);
  localparam logic [SCW-1:0] STABLE_MAX  = SCW'(STABLE_CYCLES - 1);
  localparam logic [SCW-1:0] STABLE_FIRE = SCW'(STABLE_CYCLES - 2);
  localparam logic [ACW-1:0] AGE_MAX     = ACW'(BLANK_CYCLES);

  typedef enum logic {IDLE, PRESS} press_state_t;

  press_state_t   state          [N_BTN];
  press_state_t   state_next     [N_BTN];
  logic [PCW-1:0] press_cnt      [N_BTN];
  logic [PCW-1:0] press_cnt_next [N_BTN];
  logic [N_BTN-1:0] btn_prev;

  always_comb begin
    for (int unsigned i = 0; i < N_BTN; i++) begin
      state_next[i]     = state[i];
      press_cnt_next[i] = press_cnt[i];
      if (btn_level[i]) begin
        state_next[i]     = IDLE;
        press_cnt_next[i] = '0;
      end else begin
        case (state[i])
          IDLE: begin
            if (btn_req[i] && !btn_prev[i]) begin
              state_next[i]     = PRESS;
              press_cnt_next[i] = PRESS_LOAD;
            end
          end
          PRESS: begin
            if (press_cnt[i] == PCW'(1)) begin
              state_next[i]     = IDLE;
              press_cnt_next[i] = '0;
            end else begin
              press_cnt_next[i] = press_cnt[i] - PCW'(1);
            end
          end
          default: state_next[i] = IDLE;
        endcase
      end
    end
  end

  // Outputs are registered from the current state, so a press is visible one
  // edge after the request edge and lasts exactly PRESS_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev <= '1;
      btn_out  <= '0;
      btn_busy <= '0;
      sw_out   <= '0;
      led_out  <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        state[i]     <= IDLE;
        press_cnt[i] <= '0;
      end
    end else begin
      btn_prev <= btn_req;
      sw_out   <= sw_in;
      led_out  <= led_in;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        state[i]     <= state_next[i];
        press_cnt[i] <= press_cnt_next[i];
        btn_out[i]   <= btn_level[i] ? btn_req[i] : (state[i] == PRESS);
        btn_busy[i]  <= !btn_level[i] && (state[i] == PRESS);
      end
    end
  end

  logic [SMW-1:0]        sample;
  logic [SMW-1:0]        sample_prev;
  logic [N_DIGITS-1:0]   sample_anode;
  logic [SCW-1:0]        stable_cnt;
  logic [SCW-1:0]        stable_cnt_next;
  logic [ACW-1:0]        age      [N_DIGITS];
  logic [ACW-1:0]        age_next [N_DIGITS];
  logic [8*N_DIGITS-1:0] frame_next;
  logic                  match;
  logic                  capture;

  always_comb begin
    sample_anode    = sample[SMW-1:8];
    match           = (sample == sample_prev);
    stable_cnt_next = '0;
    if (match) begin
      stable_cnt_next = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + SCW'(1);
    end
    // Fires only on the transition into STABLE_MAX, hence once per stable period.
    capture    = match && (stable_cnt == STABLE_FIRE) && $onehot(~sample_anode);
    frame_next = digit_frame;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      age_next[k] = (age[k] == AGE_MAX) ? age[k] : age[k] + ACW'(1);
      if (capture && !sample_anode[k]) begin
        frame_next[8*k +: 8] = ~sample[7:0];
        age_next[k]          = '0;
      end else if (age_next[k] == AGE_MAX) begin
        frame_next[8*k +: 8] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample       <= '1;
      sample_prev  <= '1;
      stable_cnt   <= '0;
      digit_frame  <= '0;
      frame_update <= 1'b0;
      for (int unsigned k = 0; k < N_DIGITS; k++) begin
        age[k] <= '0;
      end
    end else begin
      sample       <= {anode, dp, cathode};
      sample_prev  <= sample;
      stable_cnt   <= stable_cnt_next;
      digit_frame  <= frame_next;
      frame_update <= (frame_next != digit_frame);
      for (int unsigned k = 0; k < N_DIGITS; k++) begin
        age[k] <= age_next[k];
      end
    end
  end

endmodule

// File: tb/tb_vio_io_bridge.sv
// Scoreboard bench for vio_io_bridge: stimulus pushes time-stamped expectations,
// a monitor pops and compares them one time unit after each rising edge.
module tb_vio_io_bridge;
  localparam int P = 10;
  localparam int S = 4;
  localparam int B = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  btn_req = '0;
  logic [4:0]  btn_level = '0;
  logic [15:0] sw_in = '0;
  logic [15:0] led_in = '0;
  logic [7:0]  anode = 8'hFF;
  logic [6:0]  cathode = 7'h7F;
  logic        dp = 1'b1;
  logic [4:0]  btn_out, btn_busy;
  logic [15:0] sw_out, led_out;
  logic [63:0] digit_frame;
  logic        frame_update;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  vio_io_bridge #(
    .N_BTN(5), .N_SW(16), .N_LED(16), .N_DIGITS(8),
    .PRESS_CYCLES(P), .STABLE_CYCLES(S), .BLANK_CYCLES(B)
  ) dut (
    .clk(clk), .rst(rst), .btn_req(btn_req), .btn_level(btn_level),
    .sw_in(sw_in), .btn_out(btn_out), .btn_busy(btn_busy), .sw_out(sw_out),
    .anode(anode), .cathode(cathode), .dp(dp), .led_in(led_in),
    .led_out(led_out), .digit_frame(digit_frame), .frame_update(frame_update)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {K_SW, K_LED, K_BTN, K_BUSY, K_FRAME, K_FUPD} kind_t;
  typedef struct {int cyc; kind_t kind; int idx; logic [63:0] val;} out_exp_t;
  typedef struct {int cyc; int digit; logic [7:0] val;} frm_exp_t;

  out_exp_t out_q[$];
  frm_exp_t frm_q[$];
  logic [63:0] exp_frame = '0;

  task automatic expect_out(input int c, input kind_t k, input int idx, input logic [63:0] v);
    out_exp_t e;
    int i;
    e.cyc = c; e.kind = k; e.idx = idx; e.val = v;
    i = 0;
    while (i < out_q.size() && out_q[i].cyc <= c) i++;
    out_q.insert(i, e);
  endtask

  task automatic push_frame(input int c, input int d, input logic [7:0] v);
    frm_exp_t f;
    int i;
    f.cyc = c; f.digit = d; f.val = v;
    i = 0;
    while (i < frm_q.size() && frm_q[i].cyc <= c) i++;
    frm_q.insert(i, f);
  endtask

  always @(posedge clk) begin : monitor
    out_exp_t e;
    frm_exp_t f;
    logic [63:0] act;
    logic rst_seen;
    bit due;
    rst_seen = rst;
    #1;
    if (rst_seen) exp_frame = '0;
    while (out_q.size() > 0 && out_q[0].cyc <= cyc) begin
      e = out_q.pop_front();
      case (e.kind)
        K_SW:    act = 64'(sw_out);
        K_LED:   act = 64'(led_out);
        K_BTN:   act = 64'(btn_out[e.idx]);
        K_BUSY:  act = 64'(btn_busy[e.idx]);
        K_FRAME: act = digit_frame;
        default: act = 64'(frame_update);
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s[%0d] @cyc %0d: got %0h expected %0h", e.kind.name(), e.idx, cyc, act, e.val);
      end
    end
    due = 1'b0;
    while (frm_q.size() > 0 && frm_q[0].cyc <= cyc) begin
      f = frm_q.pop_front();
      exp_frame[8*f.digit +: 8] = f.val;
      due = 1'b1;
    end
    checks++;
    if (frame_update !== due || digit_frame !== exp_frame) begin
      errors++;
      $display("FAIL frame @cyc %0d: got update=%0b frame=%h expected update=%0b frame=%h",
               cyc, frame_update, digit_frame, due, exp_frame);
    end
  end

  task step();
    @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic show(input logic [7:0] an, input logic [7:0] seg, input int n,
                      input bit cap, input bit blank);
    int a, d;
    step();
    anode = an; dp = ~seg[7]; cathode = ~seg[6:0];
    a = cyc + 1;
    d = 0;
    for (int i = 0; i < 8; i++) if (!an[i]) d = i;
    if (cap)   push_frame(a + S, d, seg);
    if (blank) push_frame(a + S + B, d, 8'h00);
    repeat (n - 1) step();
  endtask

  task automatic idle(input int n);
    step();
    anode = 8'hFF; dp = 1'b1; cathode = 7'h7F;
    repeat (n - 1) step();
  endtask

  logic [15:0] swv  [4] = '{16'hA5C3, 16'h0000, 16'hFFFF, 16'h1234};
  logic [15:0] ledv [4] = '{16'h3C5A, 16'hFFFF, 16'h0001, 16'h8000};
  logic [7:0]  codes [8] = '{8'h3F, 8'h06, 8'h5B, 8'hCF, 8'h66, 8'h6D, 8'h7D, 8'h07};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : stim
    int k, r;
    for (int c = 1; c <= 2; c++) begin
      expect_out(c, K_SW, 0, 64'h0);
      expect_out(c, K_LED, 0, 64'h0);
      expect_out(c, K_FRAME, 0, 64'h0);
      expect_out(c, K_FUPD, 0, 64'h0);
      for (int i = 0; i < 5; i++) begin
        expect_out(c, K_BTN, i, 64'h0);
        expect_out(c, K_BUSY, i, 64'h0);
      end
    end
    step(); step();
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      sw_in = swv[i]; led_in = ledv[i];
      expect_out(cyc + 1, K_SW, 0, 64'(swv[i]));
      expect_out(cyc + 1, K_LED, 0, 64'(ledv[i]));
      step();
    end

    // timed press on button 4, ignored retrigger, accepted retrigger
    k = cyc + 1;
    btn_req[4] = 1'b1;
    for (int c = k; c <= k + 23; c++) begin
      expect_out(c, K_BTN, 4, 64'((c >= k+1 && c <= k+10) || (c >= k+12 && c <= k+21)));
      expect_out(c, K_BUSY, 4, 64'((c >= k+1 && c <= k+10) || (c >= k+12 && c <= k+21)));
    end
    step(); btn_req[4] = 1'b0;
    wait_until(k + 4); btn_req[4] = 1'b1;
    step(); btn_req[4] = 1'b0;
    wait_until(k + 10); btn_req[4] = 1'b1;
    step(); btn_req[4] = 1'b0;
    wait_until(k + 24);

    // level mode entered mid-press on button 0
    step();
    k = cyc + 1;
    btn_req[0] = 1'b1;
    for (int c = k; c <= k + 14; c++) begin
      expect_out(c, K_BTN, 0, 64'((c >= k+1 && c <= k+5) || c == k+8));
      expect_out(c, K_BUSY, 0, 64'(c >= k+1 && c <= k+3));
    end
    step(); btn_req[0] = 1'b0;
    wait_until(k + 3); btn_level[0] = 1'b1; btn_req[0] = 1'b1;
    wait_until(k + 5); btn_req[0] = 1'b0;
    wait_until(k + 7); btn_req[0] = 1'b1;
    step(); btn_req[0] = 1'b0;
    wait_until(k + 15); btn_level[0] = 1'b0;

    // request held through reset must not fire
    step();
    r = cyc + 1;
    rst = 1'b1; btn_req[1] = 1'b1; sw_in = 16'hA5C3;
    expect_out(r, K_SW, 0, 64'h0);
    expect_out(r + 1, K_SW, 0, 64'h0);
    expect_out(r + 2, K_SW, 0, 64'hA5C3);
    for (int c = r; c <= r + 15; c++) begin
      expect_out(c, K_BTN, 1, 64'h0);
      expect_out(c, K_BUSY, 1, 64'h0);
    end
    step(); step(); rst = 1'b0;
    wait_until(r + 16); btn_req[1] = 1'b0;

    // capture: too short, then just long enough
    idle(2);
    show(8'hFD, 8'h3F, 3, 1'b0, 1'b0);
    idle(3);
    show(8'hFD, 8'h3F, 4, 1'b1, 1'b1);
    idle(110);

    // invalid anode patterns
    show(8'hFC, 8'h3F, 10, 1'b0, 1'b0);
    show(8'hFF, 8'h06, 10, 1'b0, 1'b0);
    idle(2);

    // round-robin scan
    for (int d = 0; d < 8; d++) show(~(8'h01 << d), codes[d], 6, 1'b1, 1'b1);
    idle(120);

    // refresh every 90 cycles keeps digit 2 alive, then it blanks
    show(8'hFB, 8'h5B, 6, 1'b1, 1'b0);
    idle(84);
    show(8'hFB, 8'h5B, 6, 1'b0, 1'b0);
    idle(84);
    show(8'hFB, 8'h5B, 6, 1'b0, 1'b1);
    idle(110);

    // reset mid-press with a captured digit
    show(8'hDF, 8'h6D, 6, 1'b1, 1'b0);
    idle(2);
    step();
    k = cyc + 1;
    btn_req[2] = 1'b1;
    for (int c = k; c <= k + 6; c++) begin
      expect_out(c, K_BTN, 2, 64'(c == k+1 || c == k+2));
      expect_out(c, K_BUSY, 2, 64'(c == k+1 || c == k+2));
    end
    expect_out(k + 3, K_FRAME, 0, 64'h0);
    expect_out(k + 3, K_FUPD, 0, 64'h0);
    step(); btn_req[2] = 1'b0;
    wait_until(k + 2); rst = 1'b1;
    step(); rst = 1'b0;
    wait_until(k + 10);

    if (out_q.size() != 0 || frm_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending output and %0d pending frame expectations, expected 0",
               out_q.size(), frm_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
